// File: rtl/skein_round_engine.sv
// rtl/skein_round_engine.sv - iterative Threefish-1024 MIX/permute round engine
module skein_round_engine #(
   parameter int RPC = 4,
   parameter int MAX_ROUNDS = 8,
   parameter logic [511:0] ROT_TABLE = {
      8'd20, 8'd37, 8'd31, 8'd23, 8'd52, 8'd35, 8'd48, 8'd9,
      8'd25, 8'd44, 8'd42, 8'd19, 8'd46, 8'd47, 8'd44, 8'd31,
      8'd41, 8'd42, 8'd53, 8'd4,  8'd51, 8'd56, 8'd34, 8'd16,
      8'd30, 8'd44, 8'd47, 8'd12, 8'd31, 8'd37, 8'd9,  8'd41,
      8'd25, 8'd16, 8'd28, 8'd47, 8'd41, 8'd48, 8'd20, 8'd5,
      8'd17, 8'd59, 8'd41, 8'd34, 8'd13, 8'd51, 8'd4,  8'd33,
      8'd52, 8'd23, 8'd18, 8'd49, 8'd55, 8'd10, 8'd19, 8'd38,
      8'd37, 8'd22, 8'd17, 8'd8,  8'd47, 8'd8,  8'd13, 8'd24},
   localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1023:0] in_state,
   input  logic [RW-1:0] in_rounds,
   input  logic [2:0]    in_phase,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1023:0] out_state,
   output logic          busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    fsmState;
   logic [1023:0] workState;
   logic [RW-1:0] remaining;
   logic [2:0]    phase;
   logic [RW-1:0] satRounds;
   logic [RW-1:0] stepCount;
   logic [1023:0] stage [RPC+1];

   function automatic logic [63:0] rotl64(input logic [63:0] v, input logic [5:0] amt);
      // a zero amount shifts the right half out entirely, leaving v unchanged
      rotl64 = (v << amt) | (v >> (7'd64 - {1'b0, amt}));
   endfunction

   function automatic logic [1023:0] mixRound(input logic [1023:0] x, input logic [2:0] d);
      logic [63:0] f [16];
      logic [63:0] a;
      logic [63:0] b;
      for (int j = 0; j < 8; j++) begin
         a = x[j*128 +: 64];
         b = x[j*128+64 +: 64];
         f[2*j]   = a + b;
         f[2*j+1] = rotl64(b, ROT_TABLE[(int'(d)*8 + j)*8 +: 6]) ^ f[2*j];
      end
      // word i takes f[P[i]], packed with word 15 in the top bits
      mixRound = {f[1], f[8], f[5], f[14], f[3], f[12], f[7], f[10],
                  f[15], f[4], f[11], f[6], f[13], f[2], f[9], f[0]};
   endfunction

   assign in_ready  = (fsmState == IDLE);
   assign out_valid = (fsmState == DONE);
   assign busy      = (fsmState == RUN);

   // oversized round requests are clamped rather than rejected
   always_comb begin
      satRounds = (int'(in_rounds) > MAX_ROUNDS) ? RW'(MAX_ROUNDS) : in_rounds;
   end

   // rounds done this clock: RPC, or whatever is left if fewer
   always_comb begin
      stepCount = (int'(remaining) > RPC) ? RW'(RPC) : remaining;
   end

   // unrolled round cascade; stages past the remaining count pass through
   always_comb begin
      stage[0] = workState;
      for (int s = 0; s < RPC; s++) begin
         if (s < int'(remaining)) stage[s+1] = mixRound(stage[s], phase + 3'(s));
         else                     stage[s+1] = stage[s];
      end
   end

   // job sequencing: capture, iterate, hold result until accepted
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         fsmState  <= IDLE;
         workState <= '0;
         remaining <= '0;
         phase     <= '0;
         out_state <= '0;
      end else begin
         case (fsmState)
            IDLE: begin
               if (in_valid) begin
                  workState <= in_state;
                  phase     <= in_phase;
                  remaining <= satRounds;
                  if (satRounds == '0) begin
                     out_state <= in_state;
                     fsmState  <= DONE;
                  end else begin
                     fsmState  <= RUN;
                  end
               end
            end
            RUN: begin
               workState <= stage[RPC];
               remaining <= remaining - stepCount;
               phase     <= phase + 3'(stepCount);
               if (remaining == stepCount) begin
                  out_state <= stage[RPC];
                  fsmState  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) fsmState <= IDLE;
            end
            default: fsmState <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_skein_round_engine.sv
// tb/tb_skein_round_engine.sv - directed self-checking bench for skein_round_engine
module tb_skein_round_engine;

   localparam int RPC = 4;
   localparam int MAX_ROUNDS = 8;
   localparam int RW = 4;

   localparam int ROT[8][8] = '{
      '{24, 13,  8, 47,  8, 17, 22, 37},
      '{38, 19, 10, 55, 49, 18, 23, 52},
      '{33,  4, 51, 13, 34, 41, 59, 17},
      '{ 5, 20, 48, 41, 47, 28, 16, 25},
      '{41,  9, 37, 31, 12, 47, 44, 30},
      '{16, 34, 56, 51,  4, 53, 42, 41},
      '{31, 44, 47, 46, 19, 42, 44, 25},
      '{ 9, 48, 35, 52, 23, 31, 37, 20}};
   localparam int PERM[16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

   logic          clk;
   logic          nrst;
   logic          in_valid;
   logic          in_ready;
   logic [1023:0] in_state;
   logic [RW-1:0] in_rounds;
   logic [2:0]    in_phase;
   logic          out_valid;
   logic          out_ready;
   logic [1023:0] out_state;
   logic          busy;

   int errors = 0;
   int checks = 0;

   skein_round_engine #(.RPC(RPC), .MAX_ROUNDS(MAX_ROUNDS)) dut (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .in_rounds(in_rounds), .in_phase(in_phase),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      int wi;
      checks++;
      assert (obs === exp) else begin
         errors++;
         wi = 0;
         for (int i = 15; i >= 0; i--) if (obs[i*64 +: 64] !== exp[i*64 +: 64]) wi = i;
         $error("FAIL %s: word%0d observed=%h required=%h", tag, wi, obs[wi*64 +: 64], exp[wi*64 +: 64]);
      end
   endtask

   function automatic logic [1023:0] refRound(input logic [1023:0] x, input int d);
      logic [63:0] f [16];
      logic [63:0] a, b, rb;
      logic [1023:0] y;
      int r;
      for (int j = 0; j < 8; j++) begin
         a = x[128*j +: 64];
         b = x[128*j+64 +: 64];
         r = ROT[d][j];
         rb = (r == 0) ? b : ((b << r) | (b >> (64 - r)));
         f[2*j] = a + b;
         f[2*j+1] = rb ^ (a + b);
      end
      for (int i = 0; i < 16; i++) y[64*i +: 64] = f[PERM[i]];
      return y;
   endfunction

   function automatic logic [1023:0] refRun(input logic [1023:0] x, input int n, input int ph);
      int nn;
      logic [1023:0] v;
      nn = (n > MAX_ROUNDS) ? MAX_ROUNDS : n;
      v = x;
      for (int r = 0; r < nn; r++) v = refRound(v, (ph + r) % 8);
      return v;
   endfunction

   function automatic int expLat(input int n);
      int nn;
      nn = (n > MAX_ROUNDS) ? MAX_ROUNDS : n;
      return (nn + RPC - 1) / RPC;
   endfunction

   function automatic logic [1023:0] randState();
      logic [1023:0] s;
      for (int i = 0; i < 32; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   task automatic waitReady();
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
   endtask

   task automatic doJob(input logic [1023:0] st, input int rounds, input int ph,
                        output logic [1023:0] res, output int lat);
      waitReady();
      in_valid = 1'b1;
      in_state = st;
      in_rounds = RW'(rounds);
      in_phase = 3'(ph);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_state = randState();
      in_rounds = RW'($urandom);
      in_phase = 3'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = out_state;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [1023:0] st, stB, res, expA, held;
      int lat, n, ph;

      nrst = 1'b0;
      in_valid = 1'b0;
      in_state = '0;
      in_rounds = '0;
      in_phase = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_state", out_state, '0);
      nrst = 1'b1;
      @(posedge clk); #1;

      // all-zero state stays zero
      doJob('0, 8, 5, res, lat);
      chk("zero_state", res, '0);
      chk("zero_state_lat", lat, expLat(8));

      // single set bit, one round at phase 0
      st = 1024'd1;
      doJob(st, 1, 0, res, lat);
      chk("unit_word", res, 1024'd1 | (1024'd1 << 960));
      chk("unit_word_lat", lat, 1);

      // out_state holds while idle
      held = res;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_hold", out_state, held);

      // three rounds fit in one clock
      st = randState();
      doJob(st, 3, 2, res, lat);
      chk("r3_result", res, refRun(st, 3, 2));
      chk("r3_lat", lat, 1);

      // phase wraps 6,7,0,1
      st = randState();
      doJob(st, 4, 6, res, lat);
      chk("wrap_result", res, refRound(refRound(refRound(refRound(st, 6), 7), 0), 1));
      chk("wrap_lat", lat, expLat(4));

      // zero-round job passes state through
      st = randState();
      doJob(st, 0, 3, res, lat);
      chk("r0_result", res, st);
      chk("r0_lat", lat, 0);

      // oversized count saturates
      st = randState();
      doJob(st, 15, 1, res, lat);
      chk("sat_result", res, refRun(st, 8, 1));
      chk("sat_lat", lat, expLat(8));

      // random sweep against the model
      for (int i = 0; i < 200; i++) begin
         st = randState();
         n = $urandom_range(0, 8);
         ph = $urandom_range(0, 7);
         doJob(st, n, ph, res, lat);
         chk($sformatf("sweep%0d_n%0d_p%0d", i, n, ph), res, refRun(st, n, ph));
         chk($sformatf("sweep%0d_lat", i), lat, expLat(n));
      end

      // backpressure: result held, competing job ignored until released
      st = randState();
      stB = randState();
      waitReady();
      in_valid = 1'b1;
      in_state = st;
      in_rounds = RW'(5);
      in_phase = 3'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      expA = refRun(st, 5, 2);
      chk("bp_result", out_state, expA);
      in_valid = 1'b1;
      in_state = stB;
      in_rounds = RW'(2);
      in_phase = 3'd5;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_hold%0d", c), out_state, expA);
         chk($sformatf("bp_in_ready%0d", c), in_ready, 0);
         chk($sformatf("bp_out_valid%0d", c), out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_idle_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_b_busy", busy, 1);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_b_result", out_state, refRun(stB, 2, 5));
      chk("bp_b_lat", lat, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // asynchronous reset in the middle of a job
      st = randState();
      waitReady();
      in_valid = 1'b1;
      in_state = st;
      in_rounds = RW'(8);
      in_phase = 3'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      chk("midrun_busy", busy, 1);
      nrst = 1'b0;
      #1;
      chk("midrun_rst_out_valid", out_valid, 0);
      chk("midrun_rst_busy", busy, 0);
      chk("midrun_rst_in_ready", in_ready, 1);
      chk("midrun_rst_out_state", out_state, '0);
      @(posedge clk); #1;
      nrst = 1'b1;
      @(posedge clk); #1;

      // engine recovers after reset
      st = randState();
      doJob(st, 7, 4, res, lat);
      chk("post_rst_result", res, refRun(st, 7, 4));
      chk("post_rst_lat", lat, expLat(7));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
